// File: rtl/load_store_ctrl_if.sv
// ---------------------------------------------------------------------------
// load_store_ctrl_if
//   Memory-side bus between the load/store controller and the memory system.
//
//   The controller drives the request group:
//     bus_req    access in flight (high for the whole bus phase)
//     bus_we     1 = write access
//     bus_addr   doubleword-aligned byte address
//     bus_be     per-byte lane enables
//     bus_wdata  store data already shifted onto its byte lanes
//
//   The memory drives the response group:
//     bus_ack    completion strobe
//     bus_rdata  full doubleword read data
//
//   Modports:
//     master  the controller side
//     slave   the memory side
// ---------------------------------------------------------------------------
interface load_store_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_be;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_ctrl.sv
// ---------------------------------------------------------------------------
// load_store_ctrl
//   Turns a decoded load/store into a single doubleword bus access. The
//   access runs IDLE -> BUSY -> RESP -> IDLE. The pipeline is stalled while
//   the access is outstanding. If the bus does not acknowledge within
//   TIMEOUT_CYCLES BUSY cycles, the access is aborted with a fault pulse.
//
//   Parameter:
//     TIMEOUT_CYCLES  BUSY cycles without bus_ack before abort (2..255)
//
//   Ports:
//     clk        single clock, rising edge
//     reset      synchronous, active-high
//     MemRead    00/10 no read, 01 zero-extended load, 11 sign-extended load
//     MemWrite   1 = store (wins over a simultaneous read)
//     memMask    000 byte, 001 half, 011 word, 111 double
//     addr       byte address
//     wdata      right-justified store data
//     rdata      extended load result (valid in RESP, held afterwards)
//     stall      combinational pipeline hold
//     fault      one-cycle pulse in RESP for an aborted access
//     bus        load_store_ctrl_if.master
//
//   Build option MISALIGN_TRAP_EN:
//     When defined, a misaligned access faults immediately (IDLE -> RESP)
//     and never reaches the bus. When undefined, the offending low address
//     bits are silently cleared.
// ---------------------------------------------------------------------------
module load_store_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                MemRead,
  input  logic                      MemWrite,
  input  logic [2:0]                memMask,
  input  logic [63:0]               addr,
  input  logic [63:0]               wdata,
  output logic [63:0]               rdata,
  output logic                      stall,
  output logic                      fault,
  load_store_ctrl_if.master         bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [63:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_be_q, bus_be_d;
  logic [63:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  off_q, off_d;       // lane offset of the access in flight
  logic [2:0]  msk_q, msk_d;       // size mask of the access in flight
  logic        sext_q, sext_d;     // sign-extend the load result

  logic        start;
  logic [2:0]  off;
  logic [7:0]  size_be;

  assign start = MemWrite | MemRead[0];

  // Clearing the bits covered by the size mask aligns the offset down to the
  // access size; for an aligned access this is the plain address offset.
  assign off = addr[2:0] & ~memMask;

  // Right-justified lane pattern for the access size.
  always_comb begin
    case (memMask)
      3'b000:  size_be = 8'h01;
      3'b001:  size_be = 8'h03;
      3'b011:  size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (addr[2:0] & memMask) != 3'b000;
`endif

  // Truncate the right-justified bus data to the access size and extend.
  function automatic logic [63:0] extend(input logic [63:0] v,
                                         input logic [2:0]  m,
                                         input logic        s);
    case (m)
      3'b000:  extend = s ? {{56{v[7]}},  v[7:0]}  : {56'd0, v[7:0]};
      3'b001:  extend = s ? {{48{v[15]}}, v[15:0]} : {48'd0, v[15:0]};
      3'b011:  extend = s ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
      default: extend = v;
    endcase
  endfunction

  always_comb begin
    // NOTE: every *_d gets its default first so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    fault_d     = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    off_d       = off_q;
    msk_d       = msk_q;
    sext_d      = sext_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
`else
          begin
`endif
            state_d     = ST_BUSY;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = MemWrite;
            bus_addr_d  = {addr[63:3], 3'b000};
            bus_be_d    = size_be << off;
            bus_wdata_d = wdata << {off, 3'b000};
            off_d       = off;
            msk_d       = memMask;
            sext_d      = MemRead[1] & ~MemWrite;
          end
        end
      end

      ST_BUSY: begin
        if (bus.bus_ack) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          rdata_d   = bus_we_q ? 64'd0
                               : extend(bus.bus_rdata >> {off_q, 3'b000}, msk_q, sext_q);
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          // This is the last BUSY cycle the budget allows.
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
      msk_q       <= '0;
      sext_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      msk_q       <= msk_d;
      sext_q      <= sext_d;
    end
  end

  // The stall must assert in the start cycle itself, before any flop has
  // seen the request, so it is decoded from the current state and inputs.
  assign stall = !reset && (((state_q == ST_IDLE) && start) || (state_q == ST_BUSY));

  assign rdata         = rdata_q;
  assign fault         = fault_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule
